layer_out_serializer: RTL and testbench
=======================================

# layer_out_serializer

Converts one layer's parallel neuron results (NN per-neuron valid strobes plus an NN×dataWidth data bus) into the serial one-word-per-cycle `x_valid`/`x_in` stream that the next layer's neurons consume. It sits between the output of layer N and the input of layer N+1. It collects all NN results, which may arrive in any order and on any cycles, then emits them in neuron index order 0..NN-1 on consecutive cycles.

## Interface
Parameters:
- `NN`, default 10: number of neurons in the producing layer (must be ≥1).
- `dataWidth`, default 16: width of each neuron result.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-low reset.
- `i_valid`  in  NN: bit k strobes neuron k's result.
- `i_data`  in  NN*dataWidth: neuron k's result is at `[k*dataWidth +: dataWidth]`.
- `ovr_clr`  in  1: synchronous clear of `overrun`.
- `x_valid`  out  1: serial word valid; drives the next layer's `x_valid`.
- `x_out`  out  dataWidth: serial word; drives the next layer's `x_in`.
- `x_last`  out  1: marks word NN-1.
- `busy`  out  1: high while in STREAM.
- `overrun`  out  1: sticky flag; set when a result was dropped or overwritten.

## Operation
- State: `buf[0..NN-1]` holds the results, `flag[NN-1:0]` marks captured results, and `idx` (index width is clog2(NN), minimum 1) points at the next word to send.
- Two states: COLLECT and STREAM.
- **COLLECT, each edge:**
  - For every k with `i_valid[k]`: `buf[k] <= i_data[k]` and `flag[k] <= 1`.
  - If `flag[k]` was already 1, the new value overwrites the old one and `overrun <= 1`.
  - If `(flag | i_valid)` is all ones: go to STREAM and set `idx <= 0`.
- **STREAM, each edge:**
  - `x_out <= buf[idx]`, `x_valid <= 1`, `x_last <= (idx == NN-1)`, `idx <= idx+1`.
  - If `idx == NN-1`: go to COLLECT and `flag <= i_valid`. Results strobed on this same edge are captured into `buf`, which is legal because `buf[NN-1]` is read before the write.
  - On any other STREAM edge, `i_valid[k]` is ignored (data dropped) and sets `overrun <= 1`.
- **Word ordering:** strictly index order 0..NN-1, never reordered.
- **Arithmetic:** data passes through bit-exact, with no sign extension or saturation.
- **`ovr_clr`:** clears `overrun` on the edge. If a new overrun event occurs on the same edge, the set wins.
- **`busy`:** equals (state == STREAM). It is not asserted during the trailing output cycle.
- **NN = 1:** COLLECT → STREAM → COLLECT. One word is emitted with `x_last` = 1.

## Timing
- **Reset values:** all outputs are 0, state = COLLECT, `flag` = 0, `idx` = 0, `buf` = 0.
- **Reset behaviour:** reset is asynchronous, so it forces `x_valid`/`x_last`/`busy` low immediately, including mid-stream. The partial stream is abandoned.
- **Latency:** the last outstanding `i_valid` sampled at the end of cycle c gives `x_valid` high in cycles c+2 .. c+NN+1. `x_last` is high only in cycle c+NN+1.
- **Stream shape:** `x_valid` is contiguous for exactly NN cycles, with no bubbles and no backpressure.
- **Back-to-back throughput:**
  - A new batch fully strobed on the final STREAM edge re-enters STREAM one edge later.
  - `x_valid` then shows a 1-cycle gap between streams.
  - Minimum period is NN+1 cycles per batch.
- **`x_out`:** holds its last value after `x_valid` falls. Consumers must qualify it with `x_valid`.

## Structure
- Shared package `nn_pkg`: state enum (COLLECT, STREAM) and a `clog2_min1` width function reused by other layer glue blocks.
- Single module with no sub-modules. The output word mux `buf[idx]` stays inline.

## Test plan
NN=4, dataWidth=16.
1. **Simultaneous strobe:** `i_valid` = 4'b1111 in cycle 10 with data 0x0001/0x0002/0x0003/0x0004 → `x_valid` high in cycles 12–15, `x_out` = 1,2,3,4, `x_last` only in cycle 15, `busy` high in cycles 11–14, `overrun` = 0.
2. **Staggered strobes:** n2 in cycle 5, n0 in cycle 7, n3 in cycle 8, n1 in cycle 9 → stream in cycles 11–14 in order n0..n3.
3. **Repeat in COLLECT:** n1 strobed with 0x00AA, then 0x00BB, before the others complete → word 1 = 0x00BB, `overrun` = 1. Pulsing `ovr_clr` → `overrun` = 0.
4. **Strobe mid-STREAM:** n0 strobed on the 2nd STREAM edge → value dropped and `overrun` = 1. All four strobed on the final STREAM edge → captured, and the next stream follows after a 1-cycle gap.
5. **Reset mid-stream:** `rst` low after word 1 → `x_valid` drops immediately. After release, a fresh batch of 0x0010..0x0013 streams correctly with no stale flags.
6. **NN=1 build:** single strobe with 0x7FFF → one word, `x_valid` and `x_last` together.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared layer-glue definitions: serializer state encoding and an index-width helper.
package nn_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      STREAM  = 1'b1
   } state_t;

   // Width of an index over n items, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : int'($clog2(n));
   endfunction

endpackage

// File: rtl/layer_out_serializer.sv
// Gathers NN parallel neuron results (any order, any cycle) and replays them as a
// contiguous one-word-per-cycle stream in neuron index order.
module layer_out_serializer
   import nn_pkg::*;
#(
   parameter int unsigned NN        = 10,
   parameter int unsigned dataWidth = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NN-1:0]             i_valid,
   input  logic [NN*dataWidth-1:0]   i_data,
   input  logic                      ovr_clr,
   output logic                      x_valid,
   output logic [dataWidth-1:0]      x_out,
   output logic                      x_last,
   output logic                      busy,
   output logic                      overrun
);

   localparam int unsigned   IW       = clog2_min1(NN);
   localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

   state_t               state, state_nxt;
   logic [NN-1:0]        flag;
   logic [IW-1:0]        idx;
   logic [dataWidth-1:0] data_buf [NN];
   logic                 at_last;
   logic                 capture;
   logic                 ovr_evt;

   always_comb begin
      state_nxt = state;
      at_last   = (idx == LAST_IDX);
      capture   = 1'b0;
      ovr_evt   = 1'b0;
      case (state)
         COLLECT: begin
            capture = 1'b1;
            ovr_evt = |(flag & i_valid);
            if (&(flag | i_valid)) state_nxt = STREAM;
         end
         STREAM: begin
            // The final edge reads data_buf[NN-1] before the new batch lands, so capture is safe.
            if (at_last) begin
               capture   = 1'b1;
               state_nxt = COLLECT;
            end else begin
               ovr_evt = |i_valid;
            end
         end
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= COLLECT;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flag    <= '0;
         idx     <= '0;
         x_valid <= 1'b0;
         x_last  <= 1'b0;
         x_out   <= '0;
         overrun <= 1'b0;
         for (int unsigned k = 0; k < NN; k++) data_buf[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < NN; k++) begin
            if (capture && i_valid[k]) data_buf[k] <= i_data[k*dataWidth +: dataWidth];
         end

         if (state == COLLECT) begin
            flag    <= flag | i_valid;
            x_valid <= 1'b0;
            x_last  <= 1'b0;
            if (state_nxt == STREAM) idx <= '0;
         end else begin
            x_out   <= data_buf[idx];
            x_valid <= 1'b1;
            x_last  <= at_last;
            idx     <= idx + 1'b1;
            if (at_last) flag <= i_valid;
         end

         if (ovr_evt)      overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;
      end
   end

   assign busy = (state == STREAM);

endmodule

// File: tb/tb_layer_out_serializer.sv
// Scoreboard bench: stimulus queues expected words with their due cycle, a monitor checks them.
module tb_layer_out_serializer;

   localparam int unsigned NN = 4;
   localparam int unsigned DW = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [NN-1:0]    i_valid;
   logic [NN*DW-1:0] i_data;
   logic             ovr_clr;
   logic             x_valid, x_last, busy, overrun;
   logic [DW-1:0]    x_out;

   logic [0:0]       i_valid1;
   logic [DW-1:0]    i_data1;
   logic             ovr_clr1;
   logic             x_valid1, x_last1, busy1, overrun1;
   logic [DW-1:0]    x_out1;

   layer_out_serializer #(.NN(NN), .dataWidth(DW)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .ovr_clr(ovr_clr),
      .x_valid(x_valid), .x_out(x_out), .x_last(x_last), .busy(busy), .overrun(overrun)
   );

   layer_out_serializer #(.NN(1), .dataWidth(DW)) dut1 (
      .clk(clk), .rst(rst), .i_valid(i_valid1), .i_data(i_data1), .ovr_clr(ovr_clr1),
      .x_valid(x_valid1), .x_out(x_out1), .x_last(x_last1), .busy(busy1), .overrun(overrun1)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      int            cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [NN*DW-1:0] mk(input logic [NN-1:0] v, input logic [DW-1:0] d0,
                                           input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                           input logic [DW-1:0] d3);
      logic [DW-1:0]    d [NN];
      logic [NN*DW-1:0] bus;
      d = '{d0, d1, d2, d3};
      for (int i = 0; i < NN; i++) bus[i*DW +: DW] = v[i] ? d[i] : 16'hDEAD;
      return bus;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [NN-1:0] v, input logic [NN*DW-1:0] bus);
      i_valid = v;
      i_data  = bus;
      tick();
      i_valid = '0;
      i_data  = {NN{16'hDEAD}};
   endtask

   task automatic push_batch(input logic [NN*DW-1:0] bus, input int start);
      exp_t e;
      for (int i = 0; i < NN; i++) begin
         e.data = bus[i*DW +: DW];
         e.last = (i == NN - 1);
         e.cyc  = start + i;
         q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (x_valid) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got 0x%0h with nothing pending (cycle %0d)", x_out, cyc);
            end else begin
               mon_e = q.pop_front();
               chk("word_data", x_out, mon_e.data);
               chk("word_last", x_last, mon_e.last);
               chk("word_cycle", cyc, mon_e.cyc);
            end
         end else begin
            chk("last_without_valid", x_last, 0);
         end
      end
   end

   logic [NN*DW-1:0] bus;
   int c;

   initial begin
      i_valid  = '0;
      i_data   = '0;
      ovr_clr  = 1'b0;
      i_valid1 = '0;
      i_data1  = '0;
      ovr_clr1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_x_valid", x_valid, 0);
      chk("rst_x_last", x_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_x_out", x_out, 0);
      chk("rst_x_valid1", x_valid1, 0);
      rst = 1'b1;
      tick();
      tick();

      // 1: all four strobed together
      c   = cyc;
      bus = mk(4'hF, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
      push_batch(bus, c + 2);
      apply(4'hF, bus);
      for (int i = 0; i < 4; i++) begin
         chk("t1_busy_high", busy, 1);
         tick();
      end
      chk("t1_busy_low", busy, 0);
      chk("t1_overrun", overrun, 0);
      repeat (3) tick();

      // 2: staggered strobes n2, (idle), n0, n3, n1
      apply(4'b0100, mk(4'b0100, 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03));
      tick();
      apply(4'b0001, mk(4'b0001, 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03));
      apply(4'b1000, mk(4'b1000, 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03));
      chk("t2_busy_partial", busy, 0);
      c = cyc;
      push_batch(mk(4'hF, 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03), c + 2);
      apply(4'b0010, mk(4'b0010, 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03));
      repeat (6) tick();

      // 3: repeated strobe on n1 while collecting
      apply(4'b0010, mk(4'b0010, 16'h0, 16'h00AA, 16'h0, 16'h0));
      chk("t3_overrun_first", overrun, 0);
      apply(4'b0010, mk(4'b0010, 16'h0, 16'h00BB, 16'h0, 16'h0));
      chk("t3_overrun_repeat", overrun, 1);
      c = cyc;
      push_batch(mk(4'hF, 16'h0030, 16'h00BB, 16'h0032, 16'h0033), c + 2);
      apply(4'b1101, mk(4'b1101, 16'h0030, 16'h0, 16'h0032, 16'h0033));
      repeat (6) tick();
      chk("t3_overrun_sticky", overrun, 1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("t3_overrun_cleared", overrun, 0);

      // 4: strobe dropped mid-stream, then a batch on the final stream edge
      c   = cyc;
      bus = mk(4'hF, 16'h0040, 16'h0041, 16'h0042, 16'h0043);
      push_batch(bus, c + 2);
      apply(4'hF, bus);
      tick();
      apply(4'b0001, mk(4'b0001, 16'h0BAD, 16'h0, 16'h0, 16'h0));
      chk("t4_overrun_drop", overrun, 1);
      tick();
      c   = cyc;
      bus = mk(4'hF, 16'h0050, 16'h0051, 16'h0052, 16'h0053);
      push_batch(bus, c + 3);
      apply(4'hF, bus);
      chk("t4_busy_gap", busy, 0);
      tick();
      chk("t4_busy_restream", busy, 1);
      repeat (6) tick();
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("t4_overrun_cleared", overrun, 0);

      // 6: single-neuron build
      i_valid1 = 1'b1;
      i_data1  = 16'h7FFF;
      tick();
      i_valid1 = 1'b0;
      i_data1  = 16'h1234;
      chk("t6_busy1", busy1, 1);
      tick();
      @(negedge clk);
      chk("t6_x_valid1", x_valid1, 1);
      chk("t6_x_last1", x_last1, 1);
      chk("t6_x_out1", x_out1, 16'h7FFF);
      tick();
      @(negedge clk);
      chk("t6_x_valid1_low", x_valid1, 0);
      chk("t6_busy1_low", busy1, 0);
      tick();

      // 5: reset in the middle of a stream
      c   = cyc;
      bus = mk(4'hF, 16'h0060, 16'h0061, 16'h0062, 16'h0063);
      push_batch(bus, c + 2);
      apply(4'hF, bus);
      tick();
      tick();
      #6;
      rst = 1'b0;
      #1;
      chk("t5_x_valid_async", x_valid, 0);
      chk("t5_x_last_async", x_last, 0);
      chk("t5_busy_async", busy, 0);
      q.delete();
      #10;
      rst = 1'b1;
      tick();
      chk("t5_overrun_after_rst", overrun, 0);
      apply(4'b0111, mk(4'b0111, 16'h0010, 16'h0011, 16'h0012, 16'h0));
      tick();
      chk("t5_no_stale_flags", busy, 0);
      c = cyc;
      push_batch(mk(4'hF, 16'h0010, 16'h0011, 16'h0012, 16'h0013), c + 2);
      apply(4'b1000, mk(4'b1000, 16'h0, 16'h0, 16'h0, 16'h0013));

      for (int i = 0; i < 50 && q.size() != 0; i++) tick();
      chk("queue_drained", q.size(), 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
